ad9361_samp_arb: RTL and testbench

//  Merges the four gated per-channel I/Q streams from the sample filter into one

---
 rtl/ad9361_samp_arb.sv | 185 ++++++++++++++++++
 tb/tb_ad9361_samp_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_samp_arb.sv
// Four-channel sample arbiter: per-channel FIFOs feeding a round-robin,
// burst-capped scheduler that drives one ready/valid stream tagged with channel.
module ad9361_samp_arb #(
   parameter int LOG2_DEPTH = 3,
   parameter int MAX_BURST  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  valid_in,
   input  logic [95:0] data_in,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [23:0] out_data,
   output logic [1:0]  out_chan,
   output logic        out_last,
   input  logic        ovf_clr,
   output logic [3:0]  ovf
);

   localparam int NCH   = 4;
   localparam int DW    = 24;
   localparam int DEPTH = 2 ** LOG2_DEPTH;
   localparam int AW    = LOG2_DEPTH;
   localparam int PW    = LOG2_DEPTH + 1;
   localparam int BW    = $clog2(MAX_BURST + 1);

   typedef enum logic {
      S_IDLE,
      S_XFER
   } state_t;

   // FIFO storage and pointers (one extra pointer bit separates full from empty)
   logic [DW-1:0]  mem [NCH][DEPTH];
   logic [PW-1:0]  wptr [NCH];
   logic [PW-1:0]  rptr [NCH];
   logic [PW-1:0]  fill [NCH];
   logic [NCH-1:0] empty;
   logic [NCH-1:0] full;
   logic [NCH-1:0] one_left;
   logic [NCH-1:0] wr_en;
   logic [NCH-1:0] drop;

   // Scheduler state
   state_t         state, state_nxt;
   logic [1:0]     gnt, gnt_nxt;
   logic [1:0]     rr, rr_nxt;
   logic [BW-1:0]  bcnt, bcnt_nxt;
   logic [BW-1:0]  bcnt_inc;
   logic [1:0]     sel;
   logic [1:0]     cand;
   logic           any_ready;
   logic [DW-1:0]  head;
   logic           pop;
   logic           burst_done;
   logic           last_pop;

   logic           out_valid_nxt;
   logic [DW-1:0]  out_data_nxt;
   logic [1:0]     out_chan_nxt;
   logic           out_last_nxt;

   // Full is derived from registered pointers, so a write to a full FIFO is
   // dropped even if the same FIFO is popped this cycle.
   always_comb begin
      for (int n = 0; n < NCH; n++) begin
         fill[n]     = wptr[n] - rptr[n];
         empty[n]    = (wptr[n] == rptr[n]);
         full[n]     = (wptr[n][PW-1] != rptr[n][PW-1]) &&
                       (wptr[n][AW-1:0] == rptr[n][AW-1:0]);
         one_left[n] = (fill[n] == PW'(1));
         wr_en[n]    = valid_in[n] & ~full[n];
         drop[n]     = valid_in[n] & full[n];
      end
   end

   // NOTE: sample storage has no reset; pointers alone decide what is valid,
   // so clearing them on reset discards everything buffered.
   always_ff @(posedge clk) begin
      for (int n = 0; n < NCH; n++) begin
         if (wr_en[n]) begin
            mem[n][wptr[n][AW-1:0]] <= data_in[DW*n +: DW];
         end
      end
   end

   // Round-robin search starting just after the last granted channel
   always_comb begin
      sel       = rr;
      cand      = rr;
      any_ready = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         cand = rr + 2'(i);
         if (!any_ready && !empty[cand]) begin
            sel       = cand;
            any_ready = 1'b1;
         end
      end
   end

   assign head       = mem[gnt][rptr[gnt][AW-1:0]];
   assign bcnt_inc   = bcnt + 1'b1;
   assign burst_done = (bcnt_inc == BW'(MAX_BURST));
   assign pop        = (state == S_XFER) && !empty[gnt] && (!out_valid || out_ready);
   assign last_pop   = burst_done || (one_left[gnt] && !wr_en[gnt]);

   // NOTE: every variable gets its hold value first so no path leaves one
   // unassigned; combinational blocks use blocking '=' throughout.
   always_comb begin
      state_nxt     = state;
      gnt_nxt       = gnt;
      rr_nxt        = rr;
      bcnt_nxt      = bcnt;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      out_chan_nxt  = out_chan;
      out_last_nxt  = out_last;

      if (out_valid && out_ready) begin
         out_valid_nxt = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (any_ready) begin
               gnt_nxt   = sel;
               rr_nxt    = sel;
               bcnt_nxt  = '0;
               state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            if (pop) begin
               out_valid_nxt = 1'b1;
               out_data_nxt  = head;
               out_chan_nxt  = gnt;
               out_last_nxt  = last_pop;
               bcnt_nxt      = bcnt_inc;
               if (last_pop) begin
                  state_nxt = S_IDLE;
               end
            end else if (empty[gnt]) begin
               // Previous pop already flagged out_last; nothing left to send.
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // the pre-edge values computed above.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         gnt       <= 2'd0;
         rr        <= 2'd3;
         bcnt      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= 2'd0;
         out_last  <= 1'b0;
         ovf       <= '0;
         for (int n = 0; n < NCH; n++) begin
            wptr[n] <= '0;
            rptr[n] <= '0;
         end
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         rr        <= rr_nxt;
         bcnt      <= bcnt_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         out_chan  <= out_chan_nxt;
         out_last  <= out_last_nxt;
         // A new drop outranks a simultaneous clear.
         ovf       <= (ovf & ~{NCH{ovf_clr}}) | drop;
         for (int n = 0; n < NCH; n++) begin
            wptr[n] <= wptr[n] + PW'(wr_en[n]);
            rptr[n] <= rptr[n] + PW'(pop && (gnt == 2'(n)));
         end
      end
   end

endmodule

// File: tb/tb_ad9361_samp_arb.sv
// Directed self-checking bench for ad9361_samp_arb: latency, round-robin order,
// overflow, backpressure, streaming gaps and mid-grant reset.
module tb_ad9361_samp_arb;

   typedef logic [26:0] rec_t;  // {last, chan, data}

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  valid_in;
   logic [95:0] data_in;
   logic        out_ready;
   logic        out_valid;
   logic [23:0] out_data;
   logic [1:0]  out_chan;
   logic        out_last;
   logic        ovf_clr;
   logic [3:0]  ovf;

   int n_pass = 0;
   int n_chk  = 0;

   rec_t rx_q[$];
   rec_t exp_q[$];

   ad9361_samp_arb #(.LOG2_DEPTH(3), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_last  (out_last),
      .ovf_clr   (ovf_clr),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   task do_reset;
      rst_n     = 1'b0;
      valid_in  = '0;
      data_in   = '0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
   endtask

   function automatic logic [23:0] smp(input int ch, input int k);
      return 24'((ch << 20) | k);
   endfunction

   function automatic rec_t exp_rec(input int ch, input int k, input logic last);
      logic [1:0] c;
      c = 2'(ch);
      return {last, c, smp(ch, k)};
   endfunction

   task automatic set_ch(input int ch, input logic [23:0] d);
      data_in[24*ch +: 24] = d;
   endtask

   task automatic collect(input int n, input int budget);
      rx_q.delete();
      for (int c = 0; c < budget && rx_q.size() < n; c++) begin
         if (out_valid && out_ready) rx_q.push_back({out_last, out_chan, out_data});
         tick;
      end
      check("collect_count", rx_q.size(), n);
   endtask

   task automatic check_rx(input string tag, input int i, input rec_t exp);
      if (i < rx_q.size()) check(tag, rx_q[i], exp);
      else check({tag, "_missing"}, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      // ---- 1: reset state and single-sample latency on ch2 ----
      rst_n = 1'b0; valid_in = '0; data_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
      tick;
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data,  0);
      check("rst_chan",  out_chan,  0);
      check("rst_last",  out_last,  0);
      check("rst_ovf",   ovf,       0);
      rst_n = 1'b1;
      tick;
      out_ready = 1'b1;
      valid_in  = 4'b0100;
      set_ch(2, 24'h123ABC);
      tick;
      valid_in = '0;
      check("t1_lat0", out_valid, 0);
      tick;
      check("t1_lat1", out_valid, 0);
      tick;
      check("t1_valid", out_valid, 1);
      check("t1_data",  out_data,  24'h123ABC);
      check("t1_chan",  out_chan,  2);
      check("t1_last",  out_last,  1);
      tick;
      check("t1_drain", out_valid, 0);

      // ---- 2: all channels full, round-robin bursts of 4 ----
      do_reset;
      for (int k = 0; k < 8; k++) begin
         valid_in = 4'hF;
         for (int ch = 0; ch < 4; ch++) set_ch(ch, smp(ch, k));
         tick;
      end
      valid_in = '0;
      check("t2_ovf_fill", ovf, 0);
      out_ready = 1'b1;
      collect(32, 200);
      for (int i = 0; i < 32; i++) begin
         check_rx("t2_order", i, exp_rec((i % 16) / 4, (i / 16) * 4 + (i % 4), (i % 4) == 3));
      end
      check("t2_ovf_end", ovf, 0);
      check("t2_idle", out_valid, 0);

      // ---- 3: overflow on ch1 with out_ready low, clear vs drop ----
      do_reset;
      for (int k = 0; k < 11; k++) begin
         valid_in = 4'b0010;
         set_ch(1, smp(1, k));
         ovf_clr = (k == 10);
         tick;
         if (k == 8)  check("t3_ovf_before", ovf, 4'b0000);
         if (k == 9)  check("t3_ovf_drop",   ovf, 4'b0010);
         if (k == 10) check("t3_ovf_clrdrop", ovf, 4'b0010);
      end
      valid_in = '0;
      ovf_clr  = 1'b1;
      tick;
      ovf_clr = 1'b0;
      check("t3_ovf_cleared", ovf, 4'b0000);
      check("t3_held_valid", out_valid, 1);
      check("t3_held_data",  out_data, smp(1, 0));
      out_ready = 1'b1;
      collect(9, 100);
      for (int k = 0; k < 9; k++) begin
         check_rx("t3_order", k, exp_rec(1, k, (k == 3) || (k == 7) || (k == 8)));
      end
      tick;
      check("t3_no_extra", out_valid, 0);

      // ---- 4: random backpressure against a scoreboard ----
      do_reset;
      for (int k = 0; k < 6; k++) begin
         valid_in = (k < 3) ? 4'b1100 : 4'b0100;
         set_ch(2, smp(2, k));
         set_ch(3, smp(3, k));
         tick;
      end
      valid_in = '0;
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_rec(2, k, k == 3));
      for (int k = 0; k < 3; k++) exp_q.push_back(exp_rec(3, k, k == 2));
      for (int k = 4; k < 6; k++) exp_q.push_back(exp_rec(2, k, k == 5));
      begin
         logic held;
         rec_t held_rec;
         rec_t cur;
         rec_t e;
         held = 1'b0;
         held_rec = '0;
         for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            cur = {out_last, out_chan, out_data};
            if (held) check("t4_stable", {out_valid, cur}, {1'b1, held_rec});
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               e = exp_q.pop_front();
               check("t4_sample", cur, e);
               held = 1'b0;
            end else if (out_valid) begin
               held     = 1'b1;
               held_rec = cur;
            end else begin
               held = 1'b0;
            end
            tick;
         end
      end
      check("t4_left", exp_q.size(), 0);
      check("t4_ovf", ovf, 0);

      // ---- 5: continuous ch0 stream, grants of 4 with one-cycle gaps ----
      do_reset;
      out_ready = 1'b1;
      valid_in  = 4'b0001;
      set_ch(0, smp(0, 0));
      for (int j = 1; j <= 30; j++) begin
         int  m;
         logic exp_v;
         tick;
         if (j < 20) set_ch(0, smp(0, j));
         else valid_in = '0;
         m = j - 3;
         exp_v = (j >= 3) && (j <= 26) && ((m % 5) != 4);
         check("t5_valid", out_valid, exp_v);
         if (exp_v) begin
            int k;
            k = m - m / 5;
            check("t5_sample", {out_last, out_chan, out_data}, exp_rec(0, k, (k % 4) == 3));
         end
      end
      check("t5_ovf", ovf, 0);

      // ---- 6: asynchronous reset mid-grant ----
      do_reset;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         valid_in = 4'b1110;
         for (int ch = 1; ch < 4; ch++) set_ch(ch, smp(ch, k));
         tick;
      end
      valid_in = '0;
      check("t6_midgrant", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", out_valid, 0);
      check("t6_async_data",  out_data,  0);
      check("t6_async_chan",  out_chan,  0);
      check("t6_async_last",  out_last,  0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      check("t6_empty", out_valid, 0);
      valid_in = 4'b1001;
      set_ch(0, smp(0, 9));
      set_ch(3, smp(3, 9));
      tick;
      valid_in = '0;
      tick;
      tick;
      check("t6_first", {out_valid, out_last, out_chan, out_data}, {1'b1, exp_rec(0, 9, 1'b1)});
      tick;
      check("t6_bubble", out_valid, 0);
      tick;
      check("t6_second", {out_valid, out_last, out_chan, out_data}, {1'b1, exp_rec(3, 9, 1'b1)});
      tick;
      check("t6_done", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
